axi_slave_wr_mem: RTL and testbench

- AXI4 write-only responder (slave) used in simulation as the memory-side endpoint for accelerator write masters (DDR port model).
- Accepts AW/W bursts, stores beats into an internal word array with byte strobes, and returns a B response.
- Provides a registered debug read port so benches can check the stored contents.
- Read channels are outside this block's scope.

---
 rtl/axi_slave_wr_mem.sv | 195 +++++++++++++++++++
 tb/tb_axi_slave_wr_mem.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_mem.sv
// axi_slave_wr_mem
// ----------------
// AXI4 write-only responder that acts as the memory-side endpoint for
// accelerator write masters (DDR port model). It accepts one AW/W burst at a
// time, stores beats into an internal word array under byte strobes, and
// returns a B response. A registered debug port exposes the stored words.
//
// Ports
//   s00_axi_aclk / s00_axi_areset : clock (rising edge), async active-high reset
//   s00_axi_aw*                   : burst address channel (awaddr/len/size/burst)
//   s00_axi_w*                    : write data channel (wdata/wstrb/wlast)
//   s00_axi_b*                    : write response channel (OKAY / SLVERR)
//   dbg_addr / dbg_rdata          : word-indexed debug read, one-cycle latency
//   busy                          : high whenever the responder is not idle
//
// Every output comes straight from a flop; there is no input-to-output path.
module axi_slave_wr_mem #(
  parameter int                        MEM_ADDR_WIDTH = 32,
  parameter int                        MEM_DATA_WIDTH = 512,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000,
  parameter int                        DEPTH_WORDS    = 4096,
  parameter int                        BRESP_DELAY    = 2
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  input  logic [MEM_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]                    s00_axi_awlen,
  input  logic [2:0]                    s00_axi_awsize,
  input  logic [1:0]                    s00_axi_awburst,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [MEM_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [MEM_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                          s00_axi_wlast,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [MEM_DATA_WIDTH-1:0]     dbg_rdata,
  output logic                          busy
);

  localparam int BYTES    = MEM_DATA_WIDTH / 8;
  localparam int SHIFT    = $clog2(BYTES);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  // One spare bit above the largest possible start index so that stepping
  // past the end of the address space never folds back into the array.
  localparam int WIDX_W   = MEM_ADDR_WIDTH - SHIFT + 1;
  localparam int DLY_W    = (BRESP_DELAY > 1) ? $clog2(BRESP_DELAY) : 1;
  localparam int DLY_LAST = (BRESP_DELAY > 0) ? BRESP_DELAY - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP_WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [WIDX_W-1:0]     idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic [DLY_W-1:0]      dly_q, dly_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  busy_q, busy_d;
  logic [MEM_DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic                  w_hs;
  logic                  last_beat;
  logic                  in_range;

  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    beat_d    = beat_q;
    err_d     = err_q;
    dly_d     = dly_q;

    w_hs      = s00_axi_wvalid && wready_q;
    last_beat = (beat_q == {1'b0, len_q});
    in_range  = (idx_q < WIDX_W'(DEPTH_WORDS));
    mem_we    = (state_q == DATA) && w_hs && in_range;
    mem_widx  = idx_q[IDX_W-1:0];

    case (state_q)
      IDLE: begin
        if (s00_axi_awvalid && awready_q) begin
          idx_d   = WIDX_W'((s00_axi_awaddr - BASE_ADDR) >> SHIFT);
          len_d   = s00_axi_awlen;
          beat_d  = '0;
          err_d   = (s00_axi_awsize != 3'(SHIFT)) ||
                    (s00_axi_awburst != 2'b01)    ||
                    (s00_axi_awaddr < BASE_ADDR);
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // Out-of-range beats are dropped; wlast must match beat awlen.
          // The burst length follows awlen regardless of where wlast lands.
          if (!in_range || (s00_axi_wlast != last_beat)) err_d = 1'b1;
          idx_d  = idx_q + WIDX_W'(1);
          beat_d = beat_q + 9'd1;
          if (last_beat) begin
            dly_d   = '0;
            state_d = (BRESP_DELAY > 0) ? RESP_WAIT : RESP;
          end
        end
      end
      RESP_WAIT: begin
        if (dly_q == DLY_W'(DLY_LAST)) state_d = RESP;
        else                           dly_d   = dly_q + DLY_W'(1);
      end
      RESP: begin
        if (s00_axi_bready && bvalid_q) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next state so they line up with
    // the state they describe.
    awready_d   = (state_d == IDLE);
    wready_d    = (state_d == DATA);
    bvalid_d    = (state_d == RESP);
    bresp_d     = ((state_d == RESP) && err_d) ? 2'b10 : 2'b00;
    busy_d      = (state_d != IDLE);
    dbg_rdata_d = mem[dbg_addr];
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (s00_axi_areset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      dly_q       <= '0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      busy_q      <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      dly_q       <= dly_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      busy_q      <= busy_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // NOTE: the word array has no reset; its contents survive reset so a
  // burst abandoned mid-way keeps the beats it already wrote.
  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s00_axi_wstrb[b]) mem[mem_widx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign busy            = busy_q;
  assign dbg_rdata       = dbg_rdata_q;

endmodule

// File: tb/tb_axi_slave_wr_mem.sv
// Self-checking bench for axi_slave_wr_mem: directed bursts from the test
// plan plus randomized bursts, compared against a word-array reference model
// that applies the address/strobe/response rules directly.
module tb_axi_slave_wr_mem;

  localparam int          AW    = 32;
  localparam int          DW    = 512;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 4096;
  localparam int          DLY   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [NB-1:0]   wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [11:0]     dbg_addr;
  logic [DW-1:0]   dbg_rdata;
  logic            busy;

  always #5 clk = ~clk;

  axi_slave_wr_mem #(
    .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH), .BRESP_DELAY(DLY)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen), .s00_axi_awsize(awsize),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] ref_mem   [DEPTH];
  logic [DW-1:0] beat_data [256];
  logic [NB-1:0] beat_strb [256];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [NB-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Debug read: address presented at a falling edge, data visible one edge later.
  task automatic check_word(input int w);
    dbg_addr = 12'(w);
    @(negedge clk);
    check($sformatf("dbg_word_%0d", w), dbg_rdata, ref_mem[w]);
  endtask

  // Drives one AW + W burst from beat_data/beat_strb and checks the response.
  // wlast_beat: beat carrying wlast (-1 = never). gap_mode: 0 none, 1 every
  // 3rd cycle idle, 2 random idles. hold: cycles bready is held low once
  // bvalid shows. abort_after: number of beats before an async reset (-1 = none).
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int wlast_beat, input int gap_mode,
                           input int hold, input int abort_after, input string tag);
    longint start;
    bit     exp_err, gap, ok;
    int     k, c, lat;
    logic   r, v;
    logic [1:0] b0;
    start   = longint'((addr - BASE) >> 6);
    exp_err = (size != 3'd6) || (burst != 2'b01) || (addr < BASE) ||
              (start + len >= DEPTH) || (wlast_beat != len);

    check({tag, "_idle_wready"}, wready, 1'b0);
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    c = 0;
    do begin
      r = awready;
      @(negedge clk);
      c++;
    end while (!r && c < 20);
    awvalid = 1'b0;
    check({tag, "_aw_accepted"}, r, 1'b1);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_wready_open"}, wready, 1'b1);

    bready = (hold == 0);
    k = 0; c = 0;
    while (k <= len && c < 4 * len + 40) begin
      if (abort_after >= 0 && k == abort_after) break;
      gap    = (gap_mode == 1 && c % 3 == 2) || (gap_mode == 2 && $urandom_range(3) == 0);
      wvalid = !gap;
      wdata  = beat_data[k];
      wstrb  = beat_strb[k];
      wlast  = (k == wlast_beat);
      v = wvalid; r = wready;
      @(negedge clk);
      c++;
      if (v && r) begin
        if (start + k < DEPTH) ref_mem[start + k] = merge(ref_mem[start + k], beat_data[k], beat_strb[k]);
        k++;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;

    if (abort_after >= 0) begin
      check({tag, "_beats_before_abort"}, k, abort_after);
      rst = 1'b1;
      #1;
      check({tag, "_reset_outputs"}, {awready, wready, bvalid, busy}, 4'b1000);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_no_response"}, {bvalid, busy, awready}, 3'b001);
      bready = 1'b0;
      return;
    end

    check({tag, "_all_beats"}, k, len + 1);
    check({tag, "_wready_closed"}, wready, 1'b0);
    lat = 1;
    while (!bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_b_latency"}, lat, DLY + 1);
    if (hold > 0) begin
      ok = 1'b1;
      b0 = bresp;
      repeat (hold) begin
        @(negedge clk);
        if (!(bvalid === 1'b1 && bresp === b0 && awready === 1'b0 && wready === 1'b0)) ok = 1'b0;
      end
      check({tag, "_b_hold_stable"}, ok, 1'b1);
      bready = 1'b1;
    end
    check({tag, "_bresp"}, bresp, exp_err ? 2'b10 : 2'b00);
    @(negedge clk);
    check({tag, "_b_done"}, {bvalid, awready, busy}, 3'b010);
    bready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  bt;
    int          ln;

    rst = 1'b1;
    awaddr = '0; awlen = '0; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; dbg_addr = '0;
    repeat (2) @(negedge clk);

    check("reset_awready", awready, 1'b1);
    check("reset_wready", wready, 1'b0);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_bresp", bresp, 2'b00);
    check("reset_dbg_rdata", dbg_rdata, '0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat of A5 at word 0.
    beat_data[0] = {64{8'hA5}};
    beat_strb[0] = '1;
    run_burst(BASE, 0, 3'd6, 2'b01, 0, 0, 0, -1, "single");
    check_word(0);
    check("single_a5_const", dbg_rdata, {64{8'hA5}});

    // Fill the whole array with random data using maximum-length bursts.
    for (int b = 0; b < DEPTH / 256; b++) begin
      for (int k = 0; k < 256; k++) begin
        beat_data[k] = rand512();
        beat_strb[k] = '1;
      end
      run_burst(BASE + 32'(b * 256 * 64), 255, 3'd6, 2'b01, 255, 0, 0, -1, $sformatf("fill%0d", b));
    end
    for (int i = 0; i < 8; i++) check_word($urandom_range(DEPTH - 1));

    // 64-beat burst, beat k carries k, wvalid idle every third cycle.
    for (int k = 0; k < 64; k++) begin
      beat_data[k] = DW'(k);
      beat_strb[k] = '1;
    end
    run_burst(BASE, 63, 3'd6, 2'b01, 63, 1, 0, -1, "burst64");
    for (int i = 0; i < 64; i++) begin
      check_word(i);
      check($sformatf("burst64_const_%0d", i), dbg_rdata, DW'(i));
    end

    // Strobe merge on word 5.
    beat_data[0] = '1;
    beat_strb[0] = '1;
    run_burst(BASE + 32'(5 * 64), 0, 3'd6, 2'b01, 0, 0, 0, -1, "preload5");
    beat_data[0] = '0;
    beat_strb[0] = 64'h0000_0000_0000_00FF;
    run_burst(BASE + 32'(5 * 64), 0, 3'd6, 2'b01, 0, 0, 0, -1, "strobe5");
    check_word(5);
    check("strobe5_const", dbg_rdata, {{56{8'hFF}}, {8{8'h00}}});

    // Error cases.
    for (int k = 0; k < 4; k++) begin
      beat_data[k] = rand512();
      beat_strb[k] = '1;
    end
    run_burst(BASE + 32'(100 * 64), 1, 3'b101, 2'b01, 1, 0, 0, -1, "bad_size");
    check_word(100);
    run_burst(BASE + 32'((DEPTH - 2) * 64), 3, 3'd6, 2'b01, 3, 0, 0, -1, "edge");
    check_word(DEPTH - 2);
    check_word(DEPTH - 1);
    check_word(0);
    run_burst(BASE + 32'(300 * 64), 3, 3'd6, 2'b01, 1, 0, 0, -1, "early_wlast");
    check_word(303);
    run_burst(BASE + 32'(310 * 64), 2, 3'd6, 2'b01, -1, 0, 0, -1, "no_wlast");
    run_burst(BASE + 32'(320 * 64), 1, 3'd6, 2'b10, 1, 0, 0, -1, "wrap_burst");
    run_burst(BASE - 32'd64, 1, 3'd6, 2'b01, 1, 0, 0, -1, "below_base");
    check_word(1);

    // Randomized bursts with random strobes, idles and response backpressure.
    for (int t = 0; t < 6; t++) begin
      w  = $urandom_range(DEPTH - 17);
      a  = BASE + 32'(w * 64);
      ln = $urandom_range(15);
      sz = ($urandom_range(3) == 0) ? 3'd5 : 3'd6;
      bt = ($urandom_range(3) == 0) ? 2'b00 : 2'b01;
      for (int k = 0; k <= ln; k++) begin
        beat_data[k] = rand512();
        beat_strb[k] = {$urandom, $urandom};
      end
      run_burst(a, ln, sz, bt, ln, 2, $urandom_range(3), -1, $sformatf("rand%0d", t));
      check_word(w + $urandom_range(ln));
    end

    // B backpressure: bready held low for 20 cycles.
    run_burst(BASE + 32'(200 * 64), 2, 3'd6, 2'b01, 2, 0, 20, -1, "bp");
    run_burst(BASE + 32'(210 * 64), 0, 3'b100, 2'b01, 0, 0, 20, -1, "bp_err");

    // Reset after ten beats of a 64-beat burst.
    for (int k = 0; k < 64; k++) begin
      beat_data[k] = rand512();
      beat_strb[k] = '1;
    end
    run_burst(BASE, 63, 3'd6, 2'b01, 63, 0, 0, 10, "abort");
    for (int i = 0; i <= 10; i++) check_word(i);

    // Normal operation resumes after the abandoned burst.
    beat_data[0] = rand512();
    beat_strb[0] = '1;
    run_burst(BASE + 32'(7 * 64), 0, 3'd6, 2'b01, 0, 0, 0, -1, "recover");
    check_word(7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
